// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/fade controller for one PWM channel: accepts target-duty commands
// and walks the live duty one LSB per step_periods PWM periods toward the target,
// updating only on period boundaries so no period is ever truncated.
module pwm_ramp_ctrl #(
  parameter int unsigned resolution   = 8,
  parameter int unsigned dvsr         = 5,
  parameter int unsigned step_periods = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [resolution-1:0] cmd_duty,
  output logic                  cmd_ready,
  output logic [resolution-1:0] duty_cur,
  output logic                  busy,
  output logic                  period_start,
  output logic                  pwm_out
);

  localparam int unsigned q_w  = (dvsr > 1) ? $clog2(dvsr) : 1;
  localparam int unsigned pc_w = (step_periods > 1) ? $clog2(step_periods) : 1;
  localparam logic [q_w-1:0]        q_last  = q_w'(dvsr - 1);
  localparam logic [resolution-1:0] d_last  = '1;
  localparam logic [pc_w-1:0]       pc_last = pc_w'(step_periods - 1);

  typedef enum logic [0:0] {
    st_idle = 1'b0,
    st_ramp = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [q_w-1:0]        q;
  logic [q_w-1:0]        q_nxt;
  logic [resolution-1:0] d;
  logic [resolution-1:0] d_nxt;
  logic                  tick;
  logic [resolution-1:0] target;
  logic [resolution-1:0] target_nxt;
  logic [pc_w-1:0]       pc;
  logic [pc_w-1:0]       pc_nxt;
  logic [resolution-1:0] duty_nxt;

  // Ready only when idle and out of reset, so a command is never lost to a reset edge.
  assign cmd_ready = (state == st_idle) && !rst;

  // Next values of the free-running prescaler and PWM counter.
  always_comb begin
    tick  = (q == q_last);
    q_nxt = tick ? '0 : q + q_w'(1);
    d_nxt = tick ? d + resolution'(1) : d;
  end

  // Prescaler, PWM counter, period marker (pre-decoded so it is high on the wrap clk) and pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      q            <= '0;
      d            <= '0;
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      q            <= q_nxt;
      d            <= d_nxt;
      period_start <= (q_nxt == q_last) && (d_nxt == d_last);
      pwm_out      <= (d < duty_cur);
    end
  end

  // Ramp FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= st_idle;
      target   <= '0;
      pc       <= '0;
      duty_cur <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      target   <= target_nxt;
      pc       <= pc_nxt;
      duty_cur <= duty_nxt;
      busy     <= (state_nxt == st_ramp);
    end
  end

  // Command acceptance and per-period stepping of the live duty toward the target.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    pc_nxt     = pc;
    duty_nxt   = duty_cur;
    case (state)
      st_idle: begin
        if (cmd_valid) begin
          target_nxt = cmd_duty;
          pc_nxt     = '0;
          if (cmd_duty != duty_cur) begin
            state_nxt = st_ramp;
          end
        end
      end
      st_ramp: begin
        if (period_start) begin
          if (pc == pc_last) begin
            pc_nxt   = '0;
            duty_nxt = (target > duty_cur) ? duty_cur + resolution'(1)
                                           : duty_cur - resolution'(1);
            if (duty_nxt == target) begin
              state_nxt = st_idle;
            end
          end else begin
            pc_nxt = pc + pc_w'(1);
          end
        end
      end
      default: state_nxt = st_idle;
    endcase
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed command sequence with random choices, every
// output compared each clock against a cycle-count based reference model.
module tb_pwm_ramp_ctrl;

  localparam int RES  = 8;
  localparam int DVSR = 5;
  localparam int SP   = 4;
  localparam int P    = DVSR * (1 << RES);

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic [RES-1:0] cmd_duty;
  logic           cmd_ready;
  logic [RES-1:0] duty_cur;
  logic           busy;
  logic           period_start;
  logic           pwm_out;

  int tests = 0;
  int fails = 0;

  // Reference model: clocks since reset, live duty, ramp flag, target, period count.
  int m_n = 0;
  int m_duty = 0;
  int m_target = 0;
  int m_pc = 0;
  int m_acc = 0;
  bit m_ramp = 1'b0;
  bit m_pwm = 1'b0;

  pwm_ramp_ctrl #(.resolution(RES), .dvsr(DVSR), .step_periods(SP)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_duty     (cmd_duty),
    .cmd_ready    (cmd_ready),
    .duty_cur     (duty_cur),
    .busy         (busy),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock: model the edge, then compare all outputs mid-cycle.
  task automatic step();
    bit ps;
    bit pwm_nx;
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_duty = 0; m_ramp = 1'b0; m_pc = 0; m_pwm = 1'b0;
    end else begin
      ps     = ((m_n % P) == P - 1);
      pwm_nx = (((m_n / DVSR) % (1 << RES)) < m_duty);
      if (!m_ramp) begin
        if (cmd_valid) begin
          m_acc++;
          m_target = int'(cmd_duty);
          m_pc     = 0;
          m_ramp   = (m_target != m_duty);
        end
      end else if (ps) begin
        m_pc++;
        if (m_pc == SP) begin
          m_pc   = 0;
          m_duty = m_duty + ((m_target > m_duty) ? 1 : -1);
          if (m_duty == m_target) m_ramp = 1'b0;
        end
      end
      m_pwm = pwm_nx;
      m_n++;
    end
    @(negedge clk);
    chk("duty_cur", 32'(duty_cur), 32'(m_duty));
    chk("busy", 32'(busy), 32'(m_ramp));
    chk("period_start", 32'(period_start), 32'((m_n % P) == P - 1));
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("cmd_ready", 32'(cmd_ready), 32'(!rst && !m_ramp));
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (m_ramp && k < bound) begin
      step();
      k++;
    end
    chk("ramp_finished_in_budget", 32'(busy), 32'(0));
  endtask

  initial begin
    int hi;
    int k;
    int acc0;
    int tgt;
    rst = 1'b1; cmd_valid = 1'b0; cmd_duty = '0;
    step();
    step();
    chk("reset_duty", 32'(duty_cur), 32'(0));
    chk("reset_ready_low", 32'(cmd_ready), 32'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_release", 32'(cmd_ready), 32'(1));
    repeat (P + 20) step();

    // Ramp 0 -> 3, then measure one full period of high time.
    cmd_valid = 1'b1; cmd_duty = 8'd3;
    step();
    cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'(1));
    wait_idle(16 * P);
    chk("duty_at_3", 32'(duty_cur), 32'(3));
    k = 0;
    while ((m_n % P) != P - 1 && k < 2 * P) begin step(); k++; end
    hi = 0;
    repeat (P) begin step(); hi += int'(pwm_out); end
    chk("pwm_high_clks", 32'(hi), 32'(15));

    // Ramp 3 -> 1 while a second command (5) is held and must wait for idle.
    cmd_valid = 1'b1; cmd_duty = 8'd1;
    step();
    cmd_duty = 8'd5;
    acc0 = m_acc;
    k = 0;
    while (m_acc == acc0 && k < 12 * P) begin step(); k++; end
    cmd_valid = 1'b0;
    chk("held_cmd_waited_for_1", 32'(duty_cur), 32'(1));
    chk("held_cmd_accepted", 32'(busy), 32'(1));
    wait_idle(20 * P);
    chk("duty_at_5", 32'(duty_cur), 32'(5));

    // Command equal to current duty completes without a ramp.
    cmd_valid = 1'b1; cmd_duty = 8'd5;
    step();
    cmd_valid = 1'b0;
    chk("eq_cmd_busy", 32'(busy), 32'(0));
    chk("eq_cmd_duty", 32'(duty_cur), 32'(5));
    chk("eq_cmd_ready", 32'(cmd_ready), 32'(1));

    // Reset while ramping down, at duty 2.
    cmd_valid = 1'b1; cmd_duty = RES'($urandom_range(0, 1));
    step();
    cmd_valid = 1'b0;
    k = 0;
    while (m_duty != 2 && k < 16 * P) begin step(); k++; end
    chk("reached_duty_2", 32'(duty_cur), 32'(2));
    repeat ($urandom_range(0, 200)) step();
    rst = 1'b1;
    step();
    chk("midramp_rst_duty", 32'(duty_cur), 32'(0));
    chk("midramp_rst_busy", 32'(busy), 32'(0));
    chk("midramp_rst_pwm", 32'(pwm_out), 32'(0));
    rst = 1'b0;

    // Random short ramp after reset, checks counter restart via period_start timing.
    repeat ($urandom_range(1, 300)) step();
    tgt = int'($urandom_range(1, 3));
    cmd_valid = 1'b1; cmd_duty = RES'(tgt);
    step();
    cmd_valid = 1'b0;
    wait_idle(16 * P);
    chk("random_target", 32'(duty_cur), 32'(tgt));
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
